// File: rtl/lsu_handshake.sv
// rtl/lsu_handshake.sv - load/store unit with req/ack memory handshake
//
// Purpose: takes the ALU result as effective address, aligns store data into
// byte lanes, drives a req/ack data-memory bus, stalls the core while the
// access is outstanding and returns a sign/zero-extended load result.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_alu_data            effective address
//   i_st_data             store data (rs2)
//   i_lsu_rden/wren       load/store in execute (both high = store)
//   i_funct3              access size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   i_mem_ack/rdata       memory completion strobe and read word
//   o_mem_req/we/addr/wdata/bmask  memory request channel
//   o_ld_data             extended load result
//   o_stall               freeze PC/regfile write
//   o_misalign            misaligned-access flag (combinational)
//   o_bus_err             one-cycle timeout pulse
module lsu_handshake #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_alu_data,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_rden,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic [31:0] o_ld_data,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        bus_err_q, bus_err_d;

  // Access decode on the live execute-stage inputs
  logic        acc;
  logic        is_b, is_h, is_w;
  logic        misalign_raw;
  logic        start;
  logic        timeout;
  logic [1:0]  off;

  assign acc  = i_lsu_rden | i_lsu_wren;
  assign off  = i_alu_data[1:0];
  assign is_b = (i_funct3 == 3'd0) || (i_funct3 == 3'd4);
  assign is_h = (i_funct3 == 3'd1) || (i_funct3 == 3'd5);
  // Anything not byte or half (including 3, 6, 7) is a word access
  assign is_w = ~is_b & ~is_h;
  assign misalign_raw = (is_h & off[0]) | (is_w & (off != 2'b00));
  assign start   = (state_q == S_IDLE) & acc & ~misalign_raw;
  assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Store lane placement
  logic [3:0]  st_bmask;
  logic [31:0] st_wdata;

  always_comb begin
    st_bmask = 4'b1111;
    st_wdata = i_st_data;
    if (is_b) begin
      st_bmask = 4'b0001 << off;
      st_wdata = {4{i_st_data[7:0]}};
    end else if (is_h) begin
      st_bmask = 4'b0011 << off;
      st_wdata = {2{i_st_data[15:0]}};
    end
  end

  // Load extraction uses the latched address/size, not the live inputs
  logic [31:0] byte_shift, half_shift, ld_ext;

  always_comb begin
    byte_shift = i_mem_rdata >> {addr_q[1:0], 3'b000};
    half_shift = i_mem_rdata >> {addr_q[1], 4'b0000};
    case (funct3_q)
      3'd0:    ld_ext = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'd4:    ld_ext = {24'd0, byte_shift[7:0]};
      3'd1:    ld_ext = {{16{half_shift[15]}}, half_shift[15:0]};
      3'd5:    ld_ext = {16'd0, half_shift[15:0]};
      default: ld_ext = i_mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   if (i_mem_ack || timeout) state_d = S_DONE;
      // DONE always returns to IDLE so a held rden/wren cannot re-trigger
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_mem_req  = 1'b0;
    o_stall    = 1'b0;
    o_misalign = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_stall    = start;
        o_misalign = acc & misalign_raw;
      end
      S_REQ: begin
        o_mem_req = 1'b1;
        o_stall   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = '0;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    bmask_d   = bmask_q;
    ld_data_d = ld_data_q;
    bus_err_d = 1'b0;
    if (start) begin
      addr_d   = i_alu_data;
      funct3_d = i_funct3;
      we_d     = i_lsu_wren;
      wdata_d  = i_lsu_wren ? st_wdata : 32'd0;
      bmask_d  = i_lsu_wren ? st_bmask : 4'b1111;
    end
    if (state_q == S_REQ) begin
      if (i_mem_ack) begin
        if (!we_q) ld_data_d = ld_ext;
      end else if (timeout) begin
        ld_data_d = 32'd0;
        bus_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      addr_q    <= 32'd0;
      funct3_q  <= 3'd0;
      we_q      <= 1'b0;
      wdata_q   <= 32'd0;
      bmask_q   <= 4'd0;
      ld_data_q <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      bmask_q   <= bmask_d;
      ld_data_q <= ld_data_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign o_mem_we    = we_q;
  assign o_mem_addr  = {addr_q[31:2], 2'b00};
  assign o_mem_wdata = wdata_q;
  assign o_mem_bmask = bmask_q;
  assign o_ld_data   = ld_data_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_lsu_handshake.sv
// tb/tb_lsu_handshake.sv - directed self-checking bench for lsu_handshake
module tb_lsu_handshake;

  logic        clk, rst_n;
  logic [31:0] alu_data, st_data, rdata;
  logic        rden, wren, ack;
  logic [2:0]  funct3;
  logic        req, we, stall, misalign, bus_err;
  logic [31:0] addr, wdata, ld_data;
  logic [3:0]  bmask;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_handshake #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_alu_data  (alu_data),
    .i_st_data   (st_data),
    .i_lsu_rden  (rden),
    .i_lsu_wren  (wren),
    .i_funct3    (funct3),
    .i_mem_ack   (ack),
    .i_mem_rdata (rdata),
    .o_mem_req   (req),
    .o_mem_we    (we),
    .o_mem_addr  (addr),
    .o_mem_wdata (wdata),
    .o_mem_bmask (bmask),
    .o_ld_data   (ld_data),
    .o_stall     (stall),
    .o_misalign  (misalign),
    .o_bus_err   (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    rden = rd; wren = wr; funct3 = f3; alu_data = a; st_data = sd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; issue(0, 0, 3'd0, 32'd0, 32'd0); ack = 1'b0; rdata = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b expected 0", req); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    n_checks++; if (ld_data !== 32'd0) begin n_fail++; $display("FAIL reset_ld: got %h expected 0", ld_data); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", bus_err); end
    n_checks++; if ({we, addr, wdata, bmask} !== 69'd0) begin n_fail++; $display("FAIL reset_regs: got we=%0b addr=%h wdata=%h bmask=%b expected all 0", we, addr, wdata, bmask); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw;
    issue(1, 0, 3'd2, 32'h100, 32'd0); #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_idle_stall: got %0b expected 1", stall); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL lw_idle_req: got %0b expected 0", req); end
    @(negedge clk);
    alu_data = 32'h102; #1;
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL lw_req_misalign_gated: got %0b expected 0", misalign); end
    n_checks++; if (req !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL lw_req: got req=%0b stall=%0b expected 1 1", req, stall); end
    n_checks++; if (addr !== 32'h100 || we !== 1'b0 || bmask !== 4'b1111) begin n_fail++; $display("FAIL lw_req_bus: got addr=%h we=%0b bmask=%b expected 100 0 1111", addr, we, bmask); end
    ack = 1'b1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    ack = 1'b0; rdata = 32'd0; rden = 1'b0; alu_data = 32'd0; #1;
    n_checks++; if (req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL lw_done: got req=%0b stall=%0b expected 0 0", req, stall); end
    n_checks++; if (ld_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", ld_data); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %0b expected 0", bus_err); end
    @(negedge clk);
    n_checks++; if (req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL lw_idle_after: got req=%0b stall=%0b expected 0 0", req, stall); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s  [3] = '{3'd0, 3'd4, 3'd1};
    logic [31:0] adrs [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, f3s[i], adrs[i], 32'd0);
      @(negedge clk);
      rden = 1'b0; ack = 1'b1; rdata = 32'h80FF1234;
      @(negedge clk);
      ack = 1'b0;
      n_checks++; if (ld_data !== exps[i]) begin n_fail++; $display("FAIL load_ext_%0d: got %h expected %h", i, ld_data, exps[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_store;
    issue(0, 1, 3'd0, 32'h201, 32'h000000AB);
    @(negedge clk);
    wren = 1'b0;
    n_checks++; if (bmask !== 4'b0010 || wdata !== 32'hABABABAB || we !== 1'b1) begin n_fail++; $display("FAIL sb_lanes: got bmask=%b wdata=%h we=%0b expected 0010 abababab 1", bmask, wdata, we); end
    n_checks++; if (addr !== 32'h200) begin n_fail++; $display("FAIL sb_addr: got %h expected 200", addr); end
    ack = 1'b1; rdata = 32'h12345678;
    @(negedge clk);
    ack = 1'b0;
    n_checks++; if (ld_data !== 32'hFFFF80FF) begin n_fail++; $display("FAIL sb_ld_hold: got %h expected ffff80ff", ld_data); end
    @(negedge clk);
    issue(1, 1, 3'd1, 32'h202, 32'h1234CDEF);
    @(negedge clk);
    rden = 1'b0; wren = 1'b0;
    n_checks++; if (bmask !== 4'b1100 || wdata !== 32'hCDEFCDEF || we !== 1'b1) begin n_fail++; $display("FAIL sh_lanes: got bmask=%b wdata=%h we=%0b expected 1100 cdefcdef 1", bmask, wdata, we); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misalign;
    issue(1, 0, 3'd2, 32'h102, 32'd0); #1;
    n_checks++; if (misalign !== 1'b1 || stall !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL lw_misalign: got mis=%0b stall=%0b req=%0b expected 1 0 0", misalign, stall, req); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (req !== 1'b0 || misalign !== 1'b1) begin n_fail++; $display("FAIL lw_misalign_hold_%0d: got req=%0b mis=%0b expected 0 1", i, req, misalign); end
    end
    issue(1, 0, 3'd1, 32'h101, 32'd0); #1;
    n_checks++; if (misalign !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL lh_misalign: got mis=%0b stall=%0b expected 1 0", misalign, stall); end
    rden = 1'b0; #1;
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_no_acc: got %0b expected 0", misalign); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int cyc = 0;
    issue(1, 0, 3'd2, 32'h300, 32'd0);
    @(negedge clk);
    rden = 1'b0;
    while (req === 1'b1 && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d expected 4", cyc); end
    n_checks++; if (bus_err !== 1'b1 || ld_data !== 32'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL timeout_done: got err=%0b ld=%h stall=%0b expected 1 0 0", bus_err, ld_data, stall); end
    @(negedge clk);
    n_checks++; if (bus_err !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got err=%0b req=%0b expected 0 0", bus_err, req); end
  endtask

  task automatic test_back_to_back;
    issue(1, 0, 3'd2, 32'h500, 32'd0);
    @(negedge clk);
    ack = 1'b1; rdata = 32'h11111111;
    @(negedge clk);
    ack = 1'b0; alu_data = 32'h504; #1;
    n_checks++; if (stall !== 1'b0 || req !== 1'b0 || ld_data !== 32'h11111111) begin n_fail++; $display("FAIL b2b_done: got stall=%0b req=%0b ld=%h expected 0 0 11111111", stall, req, ld_data); end
    @(negedge clk); #1;
    n_checks++; if (stall !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got stall=%0b req=%0b expected 1 0", stall, req); end
    @(negedge clk);
    rden = 1'b0;
    n_checks++; if (req !== 1'b1 || addr !== 32'h504) begin n_fail++; $display("FAIL b2b_req2: got req=%0b addr=%h expected 1 504", req, addr); end
    ack = 1'b1; rdata = 32'h22222222;
    @(negedge clk);
    ack = 1'b0;
    n_checks++; if (ld_data !== 32'h22222222) begin n_fail++; $display("FAIL b2b_data2: got %h expected 22222222", ld_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue(1, 0, 3'd4, 32'h100, 32'd0);
    @(negedge clk);
    rden = 1'b0; ack = 1'b1; rdata = 32'h00000055;
    @(negedge clk);
    ack = 1'b0;
    n_checks++; if (ld_data !== 32'h00000055) begin n_fail++; $display("FAIL rst_pre_load: got %h expected 55", ld_data); end
    @(negedge clk);
    issue(1, 0, 3'd2, 32'h400, 32'd0);
    @(negedge clk);
    rden = 1'b0;
    @(negedge clk);
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL rst_req2: got %0b expected 1", req); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; ack = 1'b1; rdata = 32'h12345678; #1;
    n_checks++; if (req !== 1'b0 || stall !== 1'b0 || ld_data !== 32'd0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got req=%0b stall=%0b ld=%h err=%0b expected 0 0 0 0", req, stall, ld_data, bus_err); end
    @(negedge clk);
    ack = 1'b0;
    n_checks++; if (ld_data !== 32'd0 || req !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack: got ld=%h req=%0b err=%0b expected 0 0 0", ld_data, req, bus_err); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
